// File: rtl/fft_data_input.sv
// rtl/fft_data_input.sv - sample loader: RE/IM RAMs written by software, streamed to the FFT core as AXIS {IM,RE}
module fft_data_input #(
  parameter int NFFT               = 3,
  parameter int POINT_SIZE         = 2**NFFT,
  parameter int N_ELEMENTS         = POINT_SIZE*2,
  parameter int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wEn,
  input  logic [ELEMENTS_ADDR_SIZE-1:0] wAddr,
  input  logic [31:0]                   wData,
  input  logic                          start,
  output logic                          tvalid,
  input  logic                          tready,
  output logic                          tlast,
  output logic [63:0]                   tdata,
  output logic                          busy,
  output logic                          sent
);

  localparam int PADDR = ELEMENTS_ADDR_SIZE - 1;
  localparam logic [PADDR:0]   PS      = (PADDR+1)'(POINT_SIZE);
  localparam logic [PADDR-1:0] LAST_PT = PADDR'(POINT_SIZE - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREFETCH = 2'd1;
  localparam logic [1:0] S_STREAM   = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]       state;
  logic [PADDR-1:0] beat_cnt;
  logic [31:0]      re_mem [POINT_SIZE];
  logic [31:0]      im_mem [POINT_SIZE];
  logic [31:0]      re_rd;
  logic [31:0]      im_rd;
  logic [PADDR:0]   rd_next;
  logic [PADDR-1:0] rd_point;
  logic             rd_en;
  logic             hs;

  // The RAM output register is the second pipeline slot behind tdata: it holds
  // point beat_cnt+1 and only advances on a handshake, so stalls lose nothing.
  always_comb begin
    hs      = tvalid && tready;
    rd_next = '0;
    rd_en   = 1'b0;
    case (state)
      S_IDLE: begin
        rd_next = '0;
        rd_en   = 1'b1;
      end
      S_PREFETCH, S_STREAM: begin
        rd_next = {1'b0, beat_cnt} + {{PADDR{1'b0}}, 1'b1} + {{PADDR{1'b0}}, hs};
        rd_en   = (rd_next < PS);
      end
      default: begin
        rd_next = '0;
        rd_en   = 1'b0;
      end
    endcase
    rd_point = rd_next[PADDR-1:0];
  end

  // RAM contents and read register are deliberately outside reset.
  always_ff @(posedge clk) begin
    if (wEn && !busy) begin
      if (wAddr[0]) im_mem[wAddr[ELEMENTS_ADDR_SIZE-1:1]] <= wData;
      else          re_mem[wAddr[ELEMENTS_ADDR_SIZE-1:1]] <= wData;
    end
    if (rd_en) begin
      re_rd <= re_mem[rd_point];
      im_rd <= im_mem[rd_point];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      beat_cnt <= '0;
      tvalid   <= 1'b0;
      tlast    <= 1'b0;
      tdata    <= '0;
      busy     <= 1'b0;
      sent     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          beat_cnt <= '0;
          if (start) begin
            state <= S_PREFETCH;
            busy  <= 1'b1;
          end
        end
        S_PREFETCH: begin
          state    <= S_STREAM;
          tvalid   <= 1'b1;
          tdata    <= {im_rd, re_rd};
          tlast    <= (LAST_PT == '0);
          beat_cnt <= '0;
        end
        S_STREAM: begin
          if (hs) begin
            if (tlast) begin
              state  <= S_DONE;
              tvalid <= 1'b0;
              tlast  <= 1'b0;
              sent   <= 1'b1;
            end else begin
              tdata    <= {im_rd, re_rd};
              beat_cnt <= beat_cnt + PADDR'(1);
              tlast    <= ((beat_cnt + PADDR'(1)) == LAST_PT);
            end
          end
        end
        default: begin
          sent     <= 1'b0;
          busy     <= 1'b0;
          beat_cnt <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_data_input.sv
// tb/tb_fft_data_input.sv - randomized scoreboard bench for fft_data_input
module tb_fft_data_input;
  localparam int NFFT = 3;
  localparam int P    = 2**NFFT;
  localparam int AW   = $clog2(P*2);

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          wEn = 1'b0;
  logic [AW-1:0] wAddr = '0;
  logic [31:0]   wData = '0;
  logic          start = 1'b0;
  logic          tready = 1'b0;
  logic          tvalid, tlast, busy, sent;
  logic [63:0]   tdata;

  fft_data_input #(.NFFT(NFFT)) dut (
    .clk(clk), .resetn(resetn), .wEn(wEn), .wAddr(wAddr), .wData(wData),
    .start(start), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .tdata(tdata), .busy(busy), .sent(sent)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rmode    = 0;
  int beats_seen = 0;
  int sent_total = 0;
  int first_cyc = -1, last_cyc = -1, sent_cyc = -1;
  bit seen_first = 0;
  bit prev_stall = 0;
  logic [63:0] prev_data;
  logic        prev_last;

  logic [31:0] re_m [P];
  logic [31:0] im_m [P];
  logic [63:0] exp_data [$];
  bit          exp_last [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rmode == 0) tready = 1'b1;
    else if (rmode == 1) tready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every handshake and polices AXIS stability.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(tvalid), 64'(1));
        chk("hold_data", tdata, prev_data);
        chk("hold_last", 64'(tlast), 64'(prev_last));
      end
      if (tvalid) chk("busy_with_valid", 64'(busy), 64'(1));
      if (tvalid && !seen_first) begin
        seen_first = 1;
        first_cyc  = cyc;
      end
      if (tvalid && tready) begin
        if (exp_data.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h expected no beat (cycle %0d)", tdata, cyc);
        end else begin
          chk("tdata", tdata, exp_data.pop_front());
          chk("tlast", 64'(tlast), 64'(exp_last.pop_front()));
          beats_seen++;
          last_cyc = cyc;
        end
      end
      if (sent) begin
        sent_total++;
        sent_cyc = cyc;
        chk("sent_all_delivered", 64'(exp_data.size()), 64'(0));
        chk("sent_busy", 64'(busy), 64'(1));
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
    wEn = 1'b1; wAddr = a; wData = d;
    if (a[0]) im_m[a >> 1] = d; else re_m[a >> 1] = d;
    tick();
    wEn = 1'b0;
  endtask

  task automatic push_frame();
    for (int k = 0; k < P; k++) begin
      exp_data.push_back({im_m[k], re_m[k]});
      exp_last.push_back(k == P - 1);
    end
  endtask

  // mode 0: tready high, 1: random, 2: five stalled cycles after tvalid rises
  task automatic run_frame(input int mode, input bit extra_start, input bit mid_write);
    int c0, s0, b0, i;
    rmode = (mode == 2) ? 2 : mode;
    if (mode == 2) tready = 1'b0;
    chk("busy_idle", 64'(busy), 64'(0));
    push_frame();
    s0 = sent_total; b0 = beats_seen; seen_first = 0;
    start = 1'b1; c0 = cyc;
    tick();
    start = 1'b0;
    for (int r = 1; r < 8; r++) begin
      if (r == 1) chk("busy_rise", 64'(busy), 64'(1));
      start = extra_start && (r == 3 || r == 6);
      if (mid_write && r == 4) begin
        wEn = 1'b1; wAddr = '0; wData = 32'hDEAD;
      end else wEn = 1'b0;
      if (mode == 2) begin
        if (r == 6) chk("stall_point0", tdata, {im_m[0], re_m[0]});
        tready = (r >= 7);
      end
      tick();
    end
    start = 1'b0; wEn = 1'b0;
    for (i = 0; i < 400 && sent_total == s0; i++) tick();
    if (sent_total == s0) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: got no sent pulse expected one within 400 cycles");
    end
    repeat (3) tick();
    chk("one_sent", 64'(sent_total - s0), 64'(1));
    chk("beat_count", 64'(beats_seen - b0), 64'(P));
    chk("busy_after", 64'(busy), 64'(0));
    chk("tvalid_after", 64'(tvalid), 64'(0));
    if (mode == 0) begin
      chk("first_valid_cycle", 64'(first_cyc - c0), 64'(2));
      chk("last_beat_cycle", 64'(last_cyc - c0), 64'(P + 1));
      chk("sent_cycle", 64'(sent_cyc - c0), 64'(P + 2));
    end
    rmode = 0;
  endtask

  task automatic reset_mid_frame();
    int s0, b0;
    rmode = 0;
    push_frame();
    s0 = sent_total; b0 = beats_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && (beats_seen - b0) < 4; i++) tick();
    chk("reached_beat4", 64'(beats_seen - b0), 64'(4));
    #1 resetn = 1'b0;
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'(0));
    chk("rst_tlast", 64'(tlast), 64'(0));
    chk("rst_tdata", tdata, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    exp_data.delete();
    exp_last.delete();
    tick(); tick();
    resetn = 1'b1;
    repeat (15) tick();
    chk("no_sent_after_reset", 64'(sent_total - s0), 64'(0));
  endtask

  initial begin
    resetn = 1'b0;
    tick(); tick();
    chk("reset_tvalid", 64'(tvalid), 64'(0));
    chk("reset_tlast", 64'(tlast), 64'(0));
    chk("reset_tdata", tdata, 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_sent", 64'(sent), 64'(0));
    resetn = 1'b1;
    tick();

    for (int k = 0; k < P; k++) begin
      wr(AW'(2*k), 32'h100 + 32'(k));
      wr(AW'(2*k + 1), 32'h200 + 32'(k));
    end
    run_frame(0, 0, 0);
    run_frame(1, 0, 0);
    run_frame(2, 0, 0);
    run_frame(0, 0, 1);
    run_frame(0, 0, 0);
    run_frame(1, 1, 0);
    reset_mid_frame();
    run_frame(0, 0, 0);

    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 6; j++) wr(AW'($urandom_range(0, 2*P - 1)), $urandom);
      run_frame(n % 2, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time limit expected completion");
    $fatal(1, "timeout");
  end
endmodule
